// File: rtl/regfile_pkg.sv
// Shared types, default parameters and port-slicing helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;
  localparam int unsigned DEF_NUM_WR = 2;

  typedef enum logic {CLEAR, RUN} state_t;

  // Low bit of port 'port' inside a flattened bus of w-bit fields.
  function automatic int unsigned port_lo(input int unsigned port, input int unsigned w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Reset-driven clear sequencer: zeroes entries 1..DEPTH-1, one per clock, then raises ready.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  // Last entry is all ones in the address space.
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] index_d;
  logic              ready_d;
  logic              clr_we_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= ADDR_W'(1);
      ready    <= 1'b0;
      clr_we   <= 1'b1;
    end else begin
      state    <= state_d;
      clr_addr <= index_d;
      ready    <= ready_d;
      clr_we   <= clr_we_d;
    end
  end

  always_comb begin
    state_d  = state;
    index_d  = clr_addr;
    ready_d  = ready;
    clr_we_d = clr_we;
    case (state)
      CLEAR: begin
        index_d = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_IDX) begin
          state_d  = RUN;
          ready_d  = 1'b1;
          clr_we_d = 1'b0;
        end
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads and a reset clear sequence.
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD,
  parameter int unsigned NUM_WR = DEF_NUM_WR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_dout,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_din,
  output logic                       ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_RD*DATA_W-1:0] rd_d;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign ra[k] = rd_addr[port_lo(k, ADDR_W) +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa[j] = wr_addr[port_lo(j, ADDR_W) +: ADDR_W];
    assign wd[j] = wr_din[port_lo(j, DATA_W) +: DATA_W];
  end

  // Storage: ascending port order makes the highest-numbered port win on a conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (ready) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wa[j] != '0)) mem[wa[j]] <= wd[j];
        end
      end
    end
  end

  // Read mux; entry 0 is never stored and always reads as zero.
  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ra[k] != '0) begin
        rd_d[port_lo(k, DATA_W) +: DATA_W] = mem[ra[k]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wa[j] == ra[k])) rd_d[port_lo(k, DATA_W) +: DATA_W] = wd[j];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !ready) rd_dout <= '0;
    else               rd_dout <= rd_d;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (default parameters).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_dout;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_din;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_dout (rd_dout),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_din  (wr_din),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 2'b00; wr_addr = '0; wr_din = '0; rd_addr = '0;
  endtask

  // Counts edges from now until ready is seen high; bounded.
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (ready) return;
    end
    n = -1;
  endtask

  initial begin
    int n;
    vecs[0]  = '{2'b11, 5'd5,  32'h1111_1111, 5'd5,  32'h2222_2222, 5'd5,  5'd0,
                 BYP ? 32'h2222_2222 : 32'h0, 32'h0};
    vecs[1]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd5,
                 32'h2222_2222, 32'h2222_2222};
    vecs[2]  = '{2'b11, 5'd0,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd0, 32'h0, 32'h0};
    vecs[3]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd0, 32'h0, 32'h0};
    vecs[4]  = '{2'b01, 5'd7,  32'hCAFE_0007, 5'd0,  32'h0,         5'd7,  5'd5,
                 BYP ? 32'hCAFE_0007 : 32'h0, 32'h2222_2222};
    vecs[5]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd7,
                 32'hCAFE_0007, 32'hCAFE_0007};
    vecs[6]  = '{2'b11, 5'd10, 32'h0000_AAAA, 5'd11, 32'h0000_BBBB, 5'd10, 5'd11,
                 BYP ? 32'h0000_AAAA : 32'h0, BYP ? 32'h0000_BBBB : 32'h0};
    vecs[7]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd11, 5'd10,
                 32'h0000_BBBB, 32'h0000_AAAA};
    vecs[8]  = '{2'b10, 5'd5,  32'h9999_9999, 5'd5,  32'h3333_3333, 5'd5,  5'd10,
                 BYP ? 32'h3333_3333 : 32'h2222_2222, 32'h0000_AAAA};
    vecs[9]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd3,
                 32'h3333_3333, 32'h0};
    vecs[10] = '{2'b11, 5'd12, 32'h0000_1212, 5'd0,  32'hFFFF_FFFF, 5'd12, 5'd0,
                 BYP ? 32'h0000_1212 : 32'h0, 32'h0};
    vecs[11] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd12, 5'd31,
                 32'h0000_1212, 32'h0};

    // Reset for three cycles.
    rst = 1'b1;
    idle_inputs();
    rd_addr = {5'd5, 5'd3};
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_dout0", rd_dout[31:0], 32'h0);
    check("reset_dout1", rd_dout[63:32], 32'h0);

    // Clear sequence with writes attempted to entry 3 throughout.
    @(negedge clk);
    rst = 1'b0;
    wr_en = 2'b11;
    wr_addr = {5'd3, 5'd3};
    wr_din = {32'h0000_0055, 32'h0000_0055};
    wait_ready(n);
    idle_inputs();
    check("clear_edges", 32'(n), 32'd31);

    // Every entry reads zero after the clear.
    for (int a = 1; a < 32; a += 2) begin
      @(negedge clk);
      rd_addr = {5'(a + 1), 5'(a)};
      @(posedge clk); #1;
      check("clear_rd0", rd_dout[31:0], 32'h0);
      if (a + 1 < 32) check("clear_rd1", rd_dout[63:32], 32'h0);
    end

    // Directed RUN vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr_en   = vecs[i].we;
      wr_addr = {vecs[i].wa1, vecs[i].wa0};
      wr_din  = {vecs[i].wd1, vecs[i].wd0};
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      @(posedge clk); #1;
      check($sformatf("vec%0d_dout0", i), rd_dout[31:0], vecs[i].exp0);
      check($sformatf("vec%0d_dout1", i), rd_dout[63:32], vecs[i].exp1);
    end

    // Reset from RUN, release, then reassert mid-clear.
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd7, 5'd5};
    rst = 1'b1;
    @(posedge clk); #1;
    check("run_rst_ready", {31'b0, ready}, 32'h0);
    check("run_rst_dout0", rd_dout[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midclear_ready", {31'b0, ready}, 32'h0);
    check("midclear_dout1", rd_dout[63:32], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("reclear_edges", 32'(n), 32'd31);

    // Previously written entries are zero after the re-clear.
    @(negedge clk);
    rd_addr = {5'd7, 5'd5};
    @(posedge clk); #1;
    check("reclear_rd5", rd_dout[31:0], 32'h0);
    check("reclear_rd7", rd_dout[63:32], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next generation of the pipeline's 2-read/1-write integer register file. It has configurable data width, depth, read-port count and write-port count, and synchronous registered reads. It adds a reset-driven clear sequencer that zeroes every entry, plus deterministic multi-write priority. It sits between decode (read ports) and write-back (write ports) of the MIPS core.

## Interface
Parameters:
- DATA_W, 32, width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries, entry 0 hardwired to zero
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_dout  out  NUM_RD*DATA_W  registered read data; port k at bits [k*DATA_W +: DATA_W]
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_din  in  NUM_WR*DATA_W  write data
- ready  out  1  high once the clear sequence has completed; writes accepted only when high

## Operation
- Two states, CLEAR and RUN.
  - In CLEAR, an index counter walks entries 1..DEPTH-1, writing zero to one entry per clock.
  - In RUN, the register file operates normally.
- rst high at any edge, including mid-clear or in RUN:
  - state <= CLEAR, index <= 1, ready <= 0, every rd_dout <= 0.
  - No entry is written at that edge.
- CLEAR with rst low:
  - Writes entry[index] <= 0 and increments index.
  - After writing entry DEPTH-1, goes to RUN and sets ready <= 1 at that same edge.
- During CLEAR:
  - All wr_en are ignored and the writes are dropped.
  - Every rd_dout <= 0.
- RUN writes:
  - A write happens when wr_en[j] is set and wr_addr[j] != 0.
  - Writes to address 0 are discarded.
  - If both ports target the same address in one cycle, port NUM_WR-1 wins.
- RUN reads: each rd_dout[k] is updated every edge as follows.
  - 0 if rd_addr[k] == 0.
  - Otherwise, when REGFILE_BYPASS_EN is defined: the same-cycle write data if a write in this cycle targets that address, using the winning port per the priority rule.
  - Otherwise: entry[rd_addr[k]] before this edge's writes.
- Read ports are fully independent. Any number of ports may read the same address.

## Timing
- Read latency is 1 clock: the address is sampled at edge E and the data is valid after E.
- Write latency is 1 clock: a write at edge E is visible to non-bypassed reads sampled at E+1.
- Clear duration: if rst is sampled high at E0 and low from E1 on, ready goes high after E(DEPTH-1). For ADDR_W=5 that is after E31.
- Reset values: rd_dout = 0, ready = 0, state = CLEAR, index = 1. Entry contents are defined only after the clear completes.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: same-cycle write-to-read forwarding, as described under Operation, applied only in RUN.
  - Undefined: reads return the pre-write contents, and a 1-cycle read-after-write hazard is left to the pipeline.

## Structure
- Package regfile_pkg holds:
  - State enum {CLEAR, RUN}.
  - Default parameter constants: DATA_W, ADDR_W, NUM_RD, NUM_WR.
  - Function for per-port slice extraction.
- Sub-module regfile_clear_seq holds the state, the index counter and ready. It outputs clr_we and clr_addr to the storage array.
- Storage array, write priority, and read/bypass muxing stay in the top module.

## Test plan
- Clear sequence (ADDR_W=5): assert rst for 3 cycles, then release.
  - ready is 0 for 31 edges and rises after the 31st.
  - Reads of addresses 1..31 return 0.
- Reset mid-clear: release rst, then reassert it after 10 edges and release again.
  - ready rises exactly 31 edges after the second release.
- Dual write conflict: in RUN, write port0 addr 5 = 0x1111_1111 and port1 addr 5 = 0x2222_2222 in the same cycle.
  - A read of 5 on the next cycle returns 0x2222_2222.
- Zero register: write addr 0 = 0xDEAD_BEEF.
  - Reads of addr 0 on all ports return 0.
- Bypass (macro defined): write addr 7 = 0xCAFE_0007 while rd_addr0 = 7 in the same cycle.
  - rd_dout0 = 0xCAFE_0007 after that edge.
  - With the macro undefined, rd_dout0 returns the old value (0 after clear).
- Writes during CLEAR: wr_en on addr 3 = 0x55 during clear.
  - After ready, a read of 3 returns 0.
